// File: rtl/dev_bus_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
// Device windows describe the bridge address map seen behind the bus port.
package dev_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [31:0] DEV_TIMER_BASE = 32'h0000_7F00;
  localparam logic [31:0] DEV_OUT_BASE   = 32'h0000_7F10;
  localparam logic [31:0] DEV_IN_BASE    = 32'h0000_7F20;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int CNT_W = 4;

  // One-hot grant vector for a master index.
  function automatic logic [1:0] onehot_of(input logic idx);
    return (idx == M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dev_bus_arbiter_rr.sv
// Combinational two-way grant: a lone requester wins; on a tie the winner is
// master 0 in fixed-priority mode, otherwise the master named by rr_ptr.
module rr_arbiter2
  import dev_bus_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    winner = M0;
    grant  = 2'b00;
    case (req)
      2'b01: winner = M0;
      2'b10: winner = M1;
      2'b11: winner = (FIXED_PRIO != 0) ? M0 : rr_ptr;
      default: winner = M0;
    endcase
    if (req != 2'b00) begin
      grant = onehot_of(winner);
    end
  end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Two-master sequencer for the CPU-to-device bridge: arbitrates, holds each
// access for WAIT_CYCLES, captures read data and issues a one-cycle ack.
module dev_bus_arbiter
  import dev_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int FIXED_PRIO  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  gnt
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic              lat_we;
  logic              owner;
  logic              rr_ptr;
  logic [1:0]        gnt_q;
  logic [31:0]       rdata0;
  logic [31:0]       rdata1;
  logic [1:0]        req;
  logic [1:0]        arb_grant;
  logic              arb_winner;
  logic              last_beat;

  assign req       = {m1_req, m0_req};
  assign last_beat = (state == ACCESS) && (cnt == '0);

  rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant),
    .winner (arb_winner)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req != 2'b00) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Master inputs are only looked at in IDLE; the access in flight runs
  // entirely from the latched copies.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      owner     <= M0;
      rr_ptr    <= M0;
      gnt_q     <= 2'b00;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner     <= arb_winner;
            gnt_q     <= arb_grant;
            cnt       <= CNT_LOAD;
            lat_addr  <= (arb_winner == M1) ? m1_addr  : m0_addr;
            lat_wdata <= (arb_winner == M1) ? m1_wdata : m0_wdata;
            lat_we    <= (arb_winner == M1) ? m1_we    : m0_we;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!lat_we) begin
            if (owner == M1) rdata1 <= bus_rdata;
            else             rdata0 <= bus_rdata;
          end
        end
        DONE: begin
          rr_ptr <= ~owner;
          gnt_q  <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  // Bus lines idle at zero so the bridge decodes nothing between accesses.
  assign bus_addr  = (state == ACCESS) ? lat_addr  : '0;
  assign bus_wdata = (state == ACCESS) ? lat_wdata : '0;
  assign bus_we    = last_beat && lat_we;

  assign m0_ack   = (state == DONE) && (owner == M0);
  assign m1_ack   = (state == DONE) && (owner == M1);
  assign m0_rdata = rdata0;
  assign m1_rdata = rdata1;
  assign gnt      = gnt_q;

endmodule
